keypad_scanner: RTL

//  Scans a 4x4 matrix keypad on hwclk (12 MHz), debounces presses and releases, and decodes the key.

---
 rtl/keypad_scanner_if.sv | 20 ++
 rtl/keypad_scanner.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and decoded-key signal bundle
interface keypad_scanner_if;
   logic [3:0] row;            // row sense, active-low, asynchronous to hwclk
   logic [3:0] col;            // column drive, active-low, one-cold
   logic [7:0] key;            // last accepted key code, zero-extended
   logic       key_is_digit;   // key is 0..9
   logic       button_pressed; // single-cycle strobe per accepted press

   // scanner side
   modport master (
      input  row,
      output col, key, key_is_digit, button_pressed
   );

   // keypad / downstream side
   modport slave (
      output row,
      input  col, key, key_is_digit, button_pressed
   );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce and decode
module keypad_scanner #(
   parameter int SCAN_DIV        = 3000,
   parameter int DEBOUNCE_CYCLES = 60000
) (
   input  logic              hwclk,
   input  logic              reset,
   keypad_scanner_if.master  kp
);

   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic [7:0]    key_q, key_d;
   logic          dig_q, dig_d;
   logic          bp_q, bp_d;
   logic [3:0]    rs1_q, rs_q;
   logic [3:0]    dec;

   // Lowest-numbered low row wins; the column is the one currently driven.
   function automatic logic [3:0] decode(input logic [1:0] c, input logic [3:0] r);
      logic [1:0] ri;
      logic [3:0] code;
      if (!r[0])      ri = 2'd0;
      else if (!r[1]) ri = 2'd1;
      else if (!r[2]) ri = 2'd2;
      else            ri = 2'd3;
      case ({ri, c})
         4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
         4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
         4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
         4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  default: code = 4'd13;
      endcase
      return code;
   endfunction

   // Two-flop synchroniser for the asynchronous row inputs (idle = all high).
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         rs1_q <= 4'b1111;
         rs_q  <= 4'b1111;
      end else begin
         rs1_q <= kp.row;
         rs_q  <= rs1_q;
      end
   end

   // State, counter, candidate and output registers.
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         state_q <= SCAN;
         c_q     <= 2'd0;
         cnt_q   <= '0;
         cand_q  <= 4'b1111;
         key_q   <= 8'd0;
         dig_q   <= 1'b1;
         bp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         key_q   <= key_d;
         dig_q   <= dig_d;
         bp_q    <= bp_d;
      end
   end

   // Next-state: scan columns, debounce a candidate pattern, then wait for a clean release.
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      key_d   = key_q;
      dig_d   = dig_q;
      bp_d    = 1'b0;
      dec     = decode(c_q, cand_q);
      case (state_q)
         SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               // Rows are only looked at once the column drive has settled.
               cnt_d = '0;
               if (rs_q == 4'b1111) begin
                  c_d = c_q + 2'd1;
               end else begin
                  cand_d  = rs_q;
                  state_d = DEBOUNCE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DEBOUNCE: begin
            if (rs_q != cand_q) begin
               // Any change of the full row pattern abandons this candidate.
               state_d = SCAN;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               key_d   = {4'd0, dec};
               dig_d   = (dec <= 4'd9);
               bp_d    = 1'b1;
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (rs_q != 4'b1111) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = SCAN;
               c_d     = c_q + 2'd1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase
   end

   assign kp.col            = ~(4'b0001 << c_q);
   assign kp.key            = key_q;
   assign kp.key_is_digit   = dig_q;
   assign kp.button_pressed = bp_q;

endmodule
